// File: rtl/ram128_ctrl_pkg.sv
// Shared constants and state encoding for the two-port RAM128 arbiter.
package ram128_ctrl_pkg;

  localparam int NPORT              = 2;
  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_ADDR_WIDTH = 7;
  localparam int DEPTH              = 2 ** DEFAULT_ADDR_WIDTH;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/ram128_arbiter_if.sv
// Request/response bus between the two clients and the RAM128 arbiter.
interface ram128_arbiter_if
  import ram128_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
);

  logic [NPORT-1:0]            req_valid;
  logic [NPORT-1:0]            req_ready;
  logic [NPORT-1:0]            req_we;
  logic [NPORT*ADDR_WIDTH-1:0] req_addr;
  logic [NPORT*DATA_WIDTH-1:0] req_wdata;
  logic [NPORT-1:0]            rsp_valid;
  logic [NPORT*DATA_WIDTH-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin arbiter; the parent owns last_grant.
module rr_arb2 (
  input  logic [1:0] i_pending,
  input  logic       i_last_grant,
  output logic [1:0] o_grant
);

  always_comb begin
    o_grant = 2'b00;
    case (i_pending)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      // on a tie the port that did not win last time goes first
      2'b11:   o_grant = i_last_grant ? 2'b01 : 2'b10;
      default: o_grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/ram128_arbiter.sv
// Clears the 128x32 RAM after reset, then shares its single port between two
// clients. States: INIT | zero-clear sweep, one address per cycle
//                  RUN  | round-robin service of the two holding registers
module ram128_arbiter
  import ram128_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
  parameter bit INIT_ENABLE = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  ram128_arbiter_if.slave       bus,
  output logic                  o_init_done,
  output logic                  o_ram_we,
  output logic [ADDR_WIDTH-1:0] o_ram_address,
  output logic [DATA_WIDTH-1:0] o_ram_d,
  input  logic [DATA_WIDTH-1:0] i_ram_q
);

  localparam logic [0:0] S_INIT  = ST_INIT;
  localparam logic [0:0] S_RUN   = ST_RUN;
  localparam logic [0:0] S_START = INIT_ENABLE ? S_INIT : S_RUN;

  logic [0:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_sweep;
  logic                  r_init_done;
  logic [NPORT-1:0]      r_pend;
  logic [NPORT-1:0]      r_we;
  logic [ADDR_WIDTH-1:0] r_addr  [NPORT];
  logic [DATA_WIDTH-1:0] r_wdata [NPORT];
  logic                  r_last_grant;
  logic [NPORT-1:0]      r_rsp_valid;
  logic [NPORT*DATA_WIDTH-1:0] r_rsp_rdata;

  logic                  w_run;
  logic [NPORT-1:0]      w_arb_grant;
  logic [NPORT-1:0]      w_grant;
  logic [NPORT-1:0]      w_ready;
  logic [NPORT-1:0]      w_accept;

  rr_arb2 u_arb (
    .i_pending    (r_pend),
    .i_last_grant (r_last_grant),
    .o_grant      (w_arb_grant)
  );

  assign w_run    = (r_state == S_RUN);
  assign w_grant  = w_run ? w_arb_grant : '0;
  // ready never looks at req_valid, so clients cannot form a comb loop through us
  assign w_ready  = w_run ? (~r_pend | w_grant) : '0;
  assign w_accept = bus.req_valid & w_ready;

  assign bus.req_ready = w_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign o_init_done   = r_init_done | !INIT_ENABLE;

  always_comb begin
    o_ram_we      = 1'b0;
    o_ram_address = '0;
    o_ram_d       = '0;
    if (!w_run) begin
      o_ram_we      = 1'b1;
      o_ram_address = r_sweep;
    end else if (w_grant[0]) begin
      o_ram_we      = r_we[0];
      o_ram_address = r_addr[0];
      o_ram_d       = r_wdata[0];
    end else if (w_grant[1]) begin
      o_ram_we      = r_we[1];
      o_ram_address = r_addr[1];
      o_ram_d       = r_wdata[1];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_START;
      r_sweep      <= '0;
      r_init_done  <= 1'b0;
      r_pend       <= '0;
      r_we         <= '0;
      r_last_grant <= 1'b1;
      r_rsp_valid  <= '0;
      r_rsp_rdata  <= '0;
      for (int i = 0; i < NPORT; i++) begin
        r_addr[i]  <= '0;
        r_wdata[i] <= '0;
      end
    end else begin
      r_rsp_valid <= w_grant;
      if (!w_run) begin
        r_sweep <= r_sweep + ADDR_WIDTH'(1);
        if (r_sweep == '1) begin
          r_state     <= S_RUN;
          r_init_done <= 1'b1;
        end
      end
      if (|w_grant) r_last_grant <= w_grant[1];
      for (int i = 0; i < NPORT; i++) begin
        if (w_grant[i])
          r_rsp_rdata[i*DATA_WIDTH +: DATA_WIDTH] <= r_we[i] ? '0 : i_ram_q;
        // a refill in the grant cycle keeps the entry pending
        if (w_accept[i]) begin
          r_pend[i]  <= 1'b1;
          r_we[i]    <= bus.req_we[i];
          r_addr[i]  <= bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
          r_wdata[i] <= bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        end else if (w_grant[i]) begin
          r_pend[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ram128_arbiter.sv
// Bench for ram128_arbiter: behavioural RAM, directed stimulus, response scoreboard.
module tb_ram128_arbiter;

  localparam int DW = 32;
  localparam int AW = 7;

  typedef struct {
    logic [DW-1:0] d;
    int            c;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          init_done;
  logic          ram_we;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_d;
  logic [DW-1:0] ram_q;
  logic [DW-1:0] mem [128];

  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_fail = 0;
  exp_t q0[$];
  exp_t q1[$];

  ram128_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  ram128_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .INIT_ENABLE(1'b1)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .bus           (bus.slave),
    .o_init_done   (init_done),
    .o_ram_we      (ram_we),
    .o_ram_address (ram_address),
    .o_ram_d       (ram_d),
    .i_ram_q       (ram_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  // RAM model, preloaded with garbage so the clear sweep is observable
  initial for (int i = 0; i < 128; i++) mem[i] = 32'hBAD0_0000 | i;
  always @(posedge clk) if (ram_we) mem[ram_address] <= ram_d;
  assign ram_q = mem[ram_address];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drv(int p, bit v, bit we, logic [AW-1:0] a, logic [DW-1:0] d);
    bus.req_valid[p]          = v;
    bus.req_we[p]             = we;
    bus.req_addr[p*AW +: AW]  = a;
    bus.req_wdata[p*DW +: DW] = d;
  endtask

  task automatic push(int p, logic [DW-1:0] d, int c);
    exp_t e;
    e.d = d;
    e.c = c;
    if (p == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // one request from port p issued in the current cycle, uncontended
  task automatic single(int p, bit we, logic [AW-1:0] a, logic [DW-1:0] wd, logic [DW-1:0] exp_d);
    chk("ready_single", 64'(bus.req_ready[p]), 64'd1);
    drv(p, 1'b1, we, a, wd);
    push(p, exp_d, cyc + 2);
    @(negedge clk);
    drv(p, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic sweep_check(int n);
    for (int i = 0; i < n; i++) begin
      chk("sweep_we", 64'(ram_we), 64'd1);
      chk("sweep_addr", 64'(ram_address), 64'(i));
      if (i == 0 || i == 127) begin
        chk("sweep_ready", 64'(bus.req_ready), 64'd0);
        chk("sweep_init_done", 64'(init_done), 64'd0);
        chk("sweep_d", 64'(ram_d), 64'd0);
      end
      @(negedge clk);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (bus.rsp_valid[p] === 1'b1) begin
        exp_t e;
        if ((p == 0 && q0.size() == 0) || (p == 1 && q1.size() == 0)) begin
          n_chk++;
          n_fail++;
          $display("FAIL rsp_unexpected: port %0d rsp_valid with no expected response (cycle %0d)", p, cyc);
        end else begin
          if (p == 0) e = q0.pop_front();
          else        e = q1.pop_front();
          chk($sformatf("rsp_data_p%0d", p), 64'(bus.rsp_rdata[p*DW +: DW]), 64'(e.d));
          chk($sformatf("rsp_cycle_p%0d", p), 64'(cyc), 64'(e.c));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    repeat (3) @(negedge clk);

    chk("rst_init_done", 64'(init_done), 64'd0);
    chk("rst_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
    chk("rst_ram_we", 64'(ram_we), 64'd1);
    chk("rst_ram_addr", 64'(ram_address), 64'd0);
    chk("rst_ram_d", 64'(ram_d), 64'd0);

    rst_n = 1'b1;
    sweep_check(128);
    chk("init_done_rise", 64'(init_done), 64'd1);
    chk("ready_after_init", 64'(bus.req_ready), 64'd3);
    chk("run_idle_we", 64'(ram_we), 64'd0);

    // cleared addresses read back zero
    single(0, 1'b0, 7'd100, '0, 32'h0);
    single(1, 1'b0, 7'd127, '0, 32'h0);
    single(0, 1'b0, 7'd0,   '0, 32'h0);
    repeat (3) @(negedge clk);

    // write then read on port 0
    single(0, 1'b1, 7'd5, 32'hDEADBEEF, 32'h0);
    single(0, 1'b0, 7'd5, '0, 32'hDEADBEEF);
    repeat (3) @(negedge clk);

    // prewrite via port 1 so port 0 wins the next tie
    single(1, 1'b1, 7'd3, 32'h0303_0303, 32'h0);
    single(1, 1'b1, 7'd9, 32'h0909_0909, 32'h0);
    repeat (3) @(negedge clk);

    // tie: port 0 first, then a refilled port 0 loses to port 1
    k = cyc;
    drv(0, 1'b1, 1'b0, 7'd3, '0);
    drv(1, 1'b1, 1'b0, 7'd9, '0);
    push(0, 32'h0303_0303, k + 2);
    push(1, 32'h0909_0909, k + 3);
    @(negedge clk);
    chk("tie_ready_a", 64'(bus.req_ready), 64'd1);
    drv(1, 1'b0, 1'b0, '0, '0);
    drv(0, 1'b1, 1'b1, 7'd3, 32'hAAAA_0003);
    push(0, 32'h0, k + 4);
    @(negedge clk);
    chk("tie_ready_b", 64'(bus.req_ready), 64'd2);
    drv(0, 1'b0, 1'b0, '0, '0);
    repeat (4) @(negedge clk);

    for (int j = 0; j < 6; j++) single(0, 1'b1, 7'(10 + j), 32'h1000_0000 + j, 32'h0);
    repeat (3) @(negedge clk);

    // port 1 streaming reads, valid held high
    for (int j = 0; j < 6; j++) begin
      chk("stream_ready", 64'(bus.req_ready[1]), 64'd1);
      drv(1, 1'b1, 1'b0, 7'(10 + j), '0);
      push(1, 32'h1000_0000 + j, cyc + 2);
      @(negedge clk);
    end
    drv(1, 1'b0, 1'b0, '0, '0);
    repeat (3) @(negedge clk);

    // same-address write (port 0) and read (port 1) in one cycle
    k = cyc;
    drv(0, 1'b1, 1'b1, 7'd7, 32'h1234_5678);
    drv(1, 1'b1, 1'b0, 7'd7, '0);
    push(0, 32'h0, k + 2);
    push(1, 32'h1234_5678, k + 3);
    @(negedge clk);
    drv(0, 1'b0, 1'b0, '0, '0);
    drv(1, 1'b0, 1'b0, '0, '0);
    repeat (4) @(negedge clk);

    // reset during a granted read: response must be dropped
    drv(1, 1'b1, 1'b0, 7'd5, '0);
    @(negedge clk);
    drv(1, 1'b0, 1'b0, '0, '0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("midrst_ready", 64'(bus.req_ready), 64'd0);
    chk("midrst_init_done", 64'(init_done), 64'd0);
    rst_n = 1'b1;
    sweep_check(60);
    chk("sweep_at_60", 64'(ram_address), 64'd60);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sweep_check(128);
    chk("init_done_rise2", 64'(init_done), 64'd1);
    chk("ready_after_init2", 64'(bus.req_ready), 64'd3);

    // the sweep cleared previously written data
    single(0, 1'b0, 7'd5, '0, 32'h0);
    single(1, 1'b0, 7'd7, '0, 32'h0);
    repeat (6) @(negedge clk);

    chk("q0_drained", 64'(q0.size()), 64'd0);
    chk("q1_drained", 64'(q1.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
